pipeline_hazard_ctrl: RTL and testbench

- Sequences the ID/EX pipeline register and its neighbours (PC, IF/ID, EX/MEM) in the five-stage MIPS datapath.
- Detects load-use hazards, applies branch-taken flushes and freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Drives write-enable, bubble and flush strobes to the stage registers and keeps stall/flush statistics.

---
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : ID/EX-centred hazard sequencer for the 5-stage MIPS pipe (load-use stall, branch flush, dmem freeze).
// Latency : strobes are combinational from current inputs/state; state, timeout and counters update on the next edge.
// Backpr. : a pending data-memory access freezes PC, IF/ID and ID/EX until dmemReady or the WAIT_MAX timeout.
// Optional: define HAZARD_PERF_CNT_EN to build the stallCount/flushCount counters (tied to 0 otherwise).

module pipeline_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             memBranchTaken,
  input  logic             memAccess,
  input  logic             dmemReady,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic             idExWrite,
  output logic             exMemFlush,
  output logic             pipeFrozen,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Last wait-counter value before the access is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic mem_hold;
  logic run_eval;
  logic wait_expire;

  // A load in EX whose destination (never $zero) is read by the ID instruction.
  assign load_use = exMemRead && (exRt != 5'd0) &&
                    ((idUsesRs && (idRs == exRt)) || (idUsesRt && (idRt == exRt)));

  // MEM instruction needs data memory and it has not answered yet.
  assign mem_hold = memAccess && !dmemReady;

  // RUN priorities apply in RUN and also on the MEM_WAIT release cycle,
  // so a branch held in MEM during the wait flushes as soon as it is freed.
  assign run_eval = (state_q == RUN) || dmemReady;

  assign wait_expire = (state_q == MEM_WAIT) && !dmemReady && (wait_cnt_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_hold) state_d = MEM_WAIT;
      MEM_WAIT: if (dmemReady || wait_expire) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Stage-register strobes
  always_comb begin
    pcWrite    = 1'b0;
    ifIdWrite  = 1'b0;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    idExWrite  = 1'b0;
    exMemFlush = 1'b0;
    if (run_eval) begin
      if (mem_hold) begin
        // Freeze everything; the branch (if any) stays in MEM and is honoured later.
      end else if (memBranchTaken) begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b1;
        idExWrite  = 1'b1;
        idExBubble = 1'b1;
        exMemFlush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, push one bubble into ID/EX.
        idExWrite  = 1'b1;
        idExBubble = 1'b1;
      end else begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        idExWrite = 1'b1;
      end
    end
  end

  assign pipeFrozen = (state_q == MEM_WAIT);
  assign memTimeout = mem_timeout_q;

  // Wait-cycle counter and sticky timeout flag
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == MEM_WAIT) begin
      if (dmemReady || wait_expire) begin
        wait_cnt_d = 16'd0;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
      if (wait_expire) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  // Wait counter / timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_evt;
  logic             flush_evt;

  // Every frozen cycle counts once; a bubble without a flush is a load-use stall.
  assign stall_evt = pipeFrozen || (idExBubble && !ifIdFlush);
  assign flush_evt = exMemFlush;

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a scoreboard queue and a decoupled monitor.
// Each vector is driven 1 ns after the rising edge; the monitor samples on the falling edge.
// Strobe vector bit order: {pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExWrite, exMemFlush, pipeFrozen, memTimeout}.

module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Hand-computed strobe patterns
  localparam logic [7:0] NORM = 8'b1100_1000;  // free-running
  localparam logic [7:0] LU   = 8'b0001_1000;  // load-use bubble
  localparam logic [7:0] BR   = 8'b1111_1100;  // branch flush
  localparam logic [7:0] HOLD = 8'b0000_0000;  // RUN, memory not ready
  localparam logic [7:0] FRZ  = 8'b0000_0010;  // MEM_WAIT frozen
  localparam logic [7:0] TO   = 8'b0000_0001;  // sticky timeout bit
  localparam logic [7:0] FZB  = 8'b0000_0010;  // pipeFrozen bit on release cycles

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       idRs = '0, idRt = '0, exRt = '0;
  logic             idUsesRs = 1'b0, idUsesRt = 1'b0, exMemRead = 1'b0;
  logic             memBranchTaken = 1'b0, memAccess = 1'b0, dmemReady = 1'b0;
  logic             pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExWrite, exMemFlush;
  logic             pipeFrozen, memTimeout;
  logic [CNT_W-1:0] stallCount, flushCount;

  pipeline_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt),
    .memBranchTaken(memBranchTaken), .memAccess(memAccess), .dmemReady(dmemReady),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExBubble(idExBubble), .idExWrite(idExWrite), .exMemFlush(exMemFlush),
    .pipeFrozen(pipeFrozen), .memTimeout(memTimeout),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [7:0]       s;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one cycle of inputs and queue the expected response for that cycle.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic emr, input logic [4:0] ert,
                      input logic br, input logic ma, input logic rdy,
                      input logic [7:0] es, input int sc, input int fc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; idRs = rs; idRt = rt; idUsesRs = urs; idUsesRt = urt;
    exMemRead = emr; exRt = ert; memBranchTaken = br; memAccess = ma; dmemReady = rdy;
    e.nm = nm;
    e.s  = es;
    e.sc = CNT_EN ? CNT_W'(sc) : '0;
    e.fc = CNT_EN ? CNT_W'(fc) : '0;
    sb_q.push_back(e);
  endtask

  // Monitor: pop and compare whenever a vector is pending for this cycle.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExWrite, exMemFlush, pipeFrozen, memTimeout};
        checks++;
        if (act !== e.s) begin
          errors++;
          $display("FAIL %s strobes: got %b expected %b", e.nm, act, e.s);
        end
        checks++;
        if (stallCount !== e.sc) begin
          errors++;
          $display("FAIL %s stallCount: got %0d expected %0d", e.nm, stallCount, e.sc);
        end
        checks++;
        if (flushCount !== e.fc) begin
          errors++;
          $display("FAIL %s flushCount: got %0d expected %0d", e.nm, flushCount, e.fc);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int waited;
    //   rst rs     rt     urs urt emr exRt   br ma rdy  expected       sc  fc  name
    step(0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          0,  0, "reset");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          0,  0, "idle");
    step(1, 5'd8,  5'd0,  1, 0, 1, 5'd8,  0, 0, 0,  LU,            0,  0, "lu_rs");
    step(1, 5'd8,  5'd0,  1, 0, 0, 5'd8,  0, 0, 0,  NORM,          1,  0, "lu_rs_after");
    step(1, 5'd3,  5'd5,  0, 1, 1, 5'd5,  0, 0, 0,  LU,            1,  0, "lu_rt");
    step(1, 5'd9,  5'd4,  0, 1, 1, 5'd9,  0, 0, 0,  NORM,          2,  0, "rs_unused");
    step(1, 5'd0,  5'd0,  1, 0, 1, 5'd0,  0, 0, 0,  NORM,          2,  0, "reg0");
    step(1, 5'd7,  5'd0,  1, 0, 0, 5'd7,  0, 0, 0,  NORM,          2,  0, "no_memread");
    step(1, 5'd8,  5'd0,  1, 0, 1, 5'd8,  1, 0, 0,  BR,            2,  0, "br_vs_lu");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          2,  1, "br_after");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  HOLD,          2,  1, "mw_enter");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  FRZ,           2,  1, "mw_1");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  FRZ,           3,  1, "mw_2");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 1,  NORM | FZB,    4,  1, "mw_release");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          5,  1, "mw_after");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1, 0,  HOLD,          5,  1, "mwbr_enter");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1, 0,  FRZ,           5,  1, "mwbr_wait");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1, 1,  BR | FZB,      6,  1, "mwbr_release");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          7,  2, "mwbr_after");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  HOLD,          7,  2, "to_enter");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  FRZ,           7,  2, "to_w0");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  FRZ,           8,  2, "to_w1");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  FRZ,           9,  2, "to_w2");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  FRZ,          10,  2, "to_w3");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM | TO,    11,  2, "to_set");
    step(1, 5'd6,  5'd0,  1, 0, 1, 5'd6,  0, 0, 0,  LU | TO,      11,  2, "to_sticky_lu");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM | TO,    12,  2, "to_sticky");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  HOLD | TO,    12,  2, "ar_enter");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0,  FRZ | TO,     12,  2, "ar_wait");
    step(0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          0,  0, "async_reset");
    step(0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          0,  0, "reset_held");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          0,  0, "post_reset");
    step(1, 5'd0,  5'd12, 0, 1, 1, 5'd12, 0, 0, 0,  LU,            0,  0, "post_lu");
    step(1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0,  NORM,          1,  0, "post_lu_after");

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d vectors left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
